grf_wport_arbiter: RTL
======================

Name: grf_wport_arbiter

Overview:
- Shares the single GRF write port (We3/A3/Wd3/Pc) between the pipeline write-back stage and the multi-cycle multiply/divide unit (MDU).
- Buffers MDU results that lose arbitration in a small in-order FIFO.
- Keeps a per-register pending scoreboard for in-flight MDU destinations and drives the decode-stage stall.
- Sits between W-stage/MDU and the GRF write inputs; stall output goes to the hazard unit.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, 2..8).

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low; clears all state.
- Wb_Valid  in  1  pipeline W-stage write request. Always accepted.
- Wb_Addr  in  5  pipeline destination register.
- Wb_Data  in  32  pipeline write data.
- Wb_Pc  in  32  pipeline instruction PC.
- Mdu_Valid  in  1  MDU result valid.
- Mdu_Ready  out  1  FIFO can accept an MDU result.
- Mdu_Addr  in  5  MDU destination.
- Mdu_Data  in  32  MDU result.
- Mdu_Pc  in  32  MDU instruction PC.
- Iss_Valid  in  1  decode issues an MDU op writing a GPR.
- Iss_Addr  in  5  that op's destination.
- Rs_Addr  in  5  decode source address 1.
- Rs_Use  in  1  Rs_Addr is read.
- Rt_Addr  in  5  decode source address 2.
- Rt_Use  in  1  Rt_Addr is read.
- Stall  out  1  decode must hold.
- Grf_We  out  1  registered GRF write enable.
- Grf_A3  out  5  registered write address.
- Grf_Wd  out  32  registered write data.
- Grf_Pc  out  32  registered PC, used by the GRF write trace.
- Waw_Err  out  1  sticky: pipeline wrote a pending register.

Behaviour:
- Reset low (async): Grf_We=0, Grf_A3=0, Grf_Wd=0, Grf_Pc=0, FIFO count=0, all pending bits=0, Waw_Err=0. Mdu_Ready=1 and Stall=0 follow from this state.
- A Mdu_Valid&Mdu_Ready handshake completes on a rising edge.
- Mdu_Ready = (count < DEPTH). It is a function of count only; same-cycle pops do not raise it.
- Arbitration and output register, loaded every edge:
  - Priority 1: Wb_Valid. The output register takes the Wb fields. An accepted MDU result is pushed.
  - Priority 2: FIFO non-empty. The output takes the FIFO head (pop). An accepted MDU result is pushed in the same edge.
  - Priority 3: MDU handshake with an empty FIFO. The result bypasses straight to the output; no push.
  - Otherwise Grf_We=0. A3/Wd/Pc hold their last values.
- Latency: 1 cycle from request to Grf_We. MDU results leave in acceptance order.
- FIFO: circular, pointers wrap modulo DEPTH. Push and pop on the same edge leave count unchanged. Push and pop at full are allowed only when no new handshake occurs (Ready=0).
- Scoreboard: pending[r] is set on an edge with Iss_Valid & !Stall & Iss_Addr!=0.
  - pending[r] clears on the edge where Grf_We=1 and Grf_A3=r and the output came from the MDU/FIFO path. The GRF commits on that same edge.
  - If set and clear hit the same register on the same edge, set wins.
  - pending[0] is always 0.
- Stall (combinational) = (Rs_Use & pending[Rs_Addr]) | (Rt_Use & pending[Rt_Addr]) | (Iss_Valid & pending[Iss_Addr]).
  - Stall deasserts the cycle after the clearing edge.
  - An issue presented while Stall=1 is ignored.
- Writes to $0 are forwarded with Grf_We=1. The GRF discards them; the trace still prints.
- Waw_Err sets when Wb_Valid & Wb_Addr!=0 & pending[Wb_Addr]. It stays set until reset.
- Reset mid-operation discards FIFO contents and pending bits immediately. Any in-flight MDU result is lost; the MDU is reset together with this block.

Test Plan:
- Reset=0 with stimulus toggling -> all outputs 0, Mdu_Ready=1. Release reset; Wb_Valid, Addr=5, Data=0x1234, Pc=0x3000 -> next edge Grf_We=1, A3=5, Wd=0x1234, Pc=0x3000.
- Same cycle: Wb(3, 0xAAAA) and Mdu(4, 0xBBBB) -> edge1 outputs reg 3, edge2 outputs reg 4. Count goes 1 then 0.
- Wb_Valid held 4 cycles while the MDU offers 3 results, DEPTH=2 -> Mdu_Ready=0 after 2 accepts. Results then drain in order with no loss once Wb drops.
- Iss_Valid, Iss_Addr=8 -> pending[8]=1. Rs_Use, Rs_Addr=8 -> Stall=1 until the MDU write of reg 8 appears on Grf_We. Stall=0 the following cycle.
- Iss_Addr=0 -> no pending set, Stall=0. Wb_Valid to reg 8 while pending[8] is set -> Waw_Err=1, and it stays 1.
- Reset pulled low with 2 FIFO entries and pending[9]=1 -> count=0, pending cleared, Grf_We=0 without waiting for a clock edge.

Source files
------------

// File: rtl/grf_wport_arbiter.sv
// Single GRF write-port arbiter: pipeline write-back wins, MDU results queue in an
// in-order FIFO, and a per-register scoreboard stalls decode on pending MDU writes.
module grf_wport_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Wb_Valid,
  input  logic [4:0]  Wb_Addr,
  input  logic [31:0] Wb_Data,
  input  logic [31:0] Wb_Pc,
  input  logic        Mdu_Valid,
  output logic        Mdu_Ready,
  input  logic [4:0]  Mdu_Addr,
  input  logic [31:0] Mdu_Data,
  input  logic [31:0] Mdu_Pc,
  input  logic        Iss_Valid,
  input  logic [4:0]  Iss_Addr,
  input  logic [4:0]  Rs_Addr,
  input  logic        Rs_Use,
  input  logic [4:0]  Rt_Addr,
  input  logic        Rt_Use,
  output logic        Stall,
  output logic        Grf_We,
  output logic [4:0]  Grf_A3,
  output logic [31:0] Grf_Wd,
  output logic [31:0] Grf_Pc,
  output logic        Waw_Err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    fifo_addr [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [31:0]   pending, pending_nxt;
  logic          src_mdu;

  logic          hs, push, pop, issue;
  logic          nxt_we, nxt_src;
  logic [4:0]    nxt_a3;
  logic [31:0]   nxt_wd, nxt_pc;

  assign Mdu_Ready = (count < CW'(DEPTH));
  assign hs        = Mdu_Valid & Mdu_Ready;

  assign Stall = (Rs_Use & pending[Rs_Addr]) |
                 (Rt_Use & pending[Rt_Addr]) |
                 (Iss_Valid & pending[Iss_Addr]);

  assign issue = Iss_Valid & ~Stall & (Iss_Addr != 5'd0);

  // Arbitration: write-back first, then the FIFO head, then an MDU bypass.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    push    = 1'b0;
    pop     = 1'b0;
    nxt_we  = 1'b0;
    nxt_src = 1'b0;
    nxt_a3  = Grf_A3;
    nxt_wd  = Grf_Wd;
    nxt_pc  = Grf_Pc;
    if (Wb_Valid) begin
      nxt_we = 1'b1;
      nxt_a3 = Wb_Addr;
      nxt_wd = Wb_Data;
      nxt_pc = Wb_Pc;
      push   = hs;
    end else if (count != '0) begin
      nxt_we  = 1'b1;
      nxt_src = 1'b1;
      nxt_a3  = fifo_addr[rd_ptr];
      nxt_wd  = fifo_data[rd_ptr];
      nxt_pc  = fifo_pc[rd_ptr];
      pop     = 1'b1;
      push    = hs;
    end else if (hs) begin
      nxt_we  = 1'b1;
      nxt_src = 1'b1;
      nxt_a3  = Mdu_Addr;
      nxt_wd  = Mdu_Data;
      nxt_pc  = Mdu_Pc;
    end
  end

  // Clear comes from the committing MDU write; a same-edge issue to that register wins.
  always_comb begin
    pending_nxt = pending;
    if (Grf_We && src_mdu) pending_nxt[Grf_A3] = 1'b0;
    if (issue) pending_nxt[Iss_Addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // NOTE: state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Grf_We  <= 1'b0;
      Grf_A3  <= 5'd0;
      Grf_Wd  <= 32'd0;
      Grf_Pc  <= 32'd0;
      src_mdu <= 1'b0;
    end else begin
      Grf_We  <= nxt_we;
      Grf_A3  <= nxt_a3;
      Grf_Wd  <= nxt_wd;
      Grf_Pc  <= nxt_pc;
      src_mdu <= nxt_src;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; count alone decides which entries are valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= Mdu_Addr;
      fifo_data[wr_ptr] <= Mdu_Data;
      fifo_pc[wr_ptr]   <= Mdu_Pc;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pending <= '0;
      Waw_Err <= 1'b0;
    end else begin
      pending <= pending_nxt;
      if (Wb_Valid && (Wb_Addr != 5'd0) && pending[Wb_Addr]) Waw_Err <= 1'b1;
    end
  end

endmodule
